// File: rtl/fetch_buffer.sv
// Instruction fetch stage: word-addressed PC generator, 1-cycle imem reads, DEPTH-entry queue to decode.
// Define FETCH_BYPASS_EN to present a returning word directly when the queue is empty.
module fetch_buffer #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     imem_rena,
   output logic [31:0]              imem_addr,
   input  logic [31:0]              imem_rdata,
   input  logic                     redirect_valid,
   input  logic [31:0]              redirect_pc,
   output logic                     inst_valid,
   input  logic                     inst_ready,
   output logic [31:0]              inst,
   output logic [31:0]              inst_pc,
   output logic [31:0]              inst_pcn,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t          state;
   logic [31:0]     fetch_pc;
   logic [31:0]     resp_pc;
   logic            resp_v;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [31:0]     mem_inst [DEPTH];
   logic [31:0]     mem_pc   [DEPTH];

   logic            bypass_hit;
   logic            accept;
   logic            push;
   logic            pop;
   logic            issue;
   logic [CW:0]     credit_used;
   logic [CW:0]     credit_cap;

`ifdef FETCH_BYPASS_EN
   assign bypass_hit = resp_v && (count == '0);
`else
   assign bypass_hit = 1'b0;
`endif

   always_comb begin
      inst_valid  = (count != '0) || bypass_hit;
      inst        = bypass_hit ? imem_rdata : mem_inst[rd_ptr];
      inst_pc     = bypass_hit ? resp_pc    : mem_pc[rd_ptr];
      inst_pcn    = inst_valid ? inst_pc + 32'd1 : '0;
      accept      = inst_valid && inst_ready;
      push        = resp_v && !(bypass_hit && inst_ready);
      pop         = accept && !bypass_hit;
      // Reads outstanding (request on the bus + response returning) hold credits;
      // a word leaving this cycle frees one, which sustains one fetch per cycle.
      credit_used = {1'b0, count} + {{CW{1'b0}}, imem_rena} + {{CW{1'b0}}, resp_v};
      credit_cap  = {1'b0, FULL} + {{CW{1'b0}}, accept};
      issue       = (state != IDLE) && (credit_used < credit_cap);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         fetch_pc  <= RESET_PC;
         imem_rena <= 1'b0;
         imem_addr <= RESET_PC;
         resp_v    <= 1'b0;
         resp_pc   <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_inst[PW'(i)] <= '0;
            mem_pc[PW'(i)]   <= '0;
         end
      end else if (redirect_valid) begin
         // The redirect target is issued on the flush edge itself, so it is on
         // the bus the cycle after the redirect; the returning stale read is dropped.
         state     <= FLUSH;
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         resp_v    <= 1'b0;
         imem_rena <= 1'b1;
         imem_addr <= redirect_pc;
         fetch_pc  <= redirect_pc + 32'd1;
      end else begin
         state   <= RUN;
         resp_v  <= imem_rena;
         resp_pc <= imem_addr;
         if (push) begin
            mem_inst[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]   <= resp_pc;
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
         if (issue) begin
            imem_rena <= 1'b1;
            imem_addr <= fetch_pc;
            fetch_pc  <= fetch_pc + 32'd1;
         end else begin
            imem_rena <= 1'b0;
         end
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(push && !redirect_valid && (count == FULL)));

endmodule
